// File: rtl/rgbw_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rgbw_pkg: shared types and constants for the multiplier-share arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rgbw_pkg;

  localparam int N_REQ = 4;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_share_arbiter_rr_pick4.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick4: combinational round-robin pick, priority starts at ptr      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_pick4
  import rgbw_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] pick
);

  logic [1:0] w_idx;
  logic       w_found;

  // Walk from ptr upward with natural 2-bit wrap; first set bit wins.
  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_share_arbiter: round-robin sharing of one 8x8 multiplier among   |
// | four requesters, with a WAIT-state timeout.                           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mult_share_arbiter
  import rgbw_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*OP_W-1:0] op_a,
  input  logic [N_REQ*OP_W-1:0] op_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic [RES_W-1:0]      res,
  output logic                  busy,
  output logic                  m_ld,
  output logic [OP_W-1:0]       m_a,
  output logic [OP_W-1:0]       m_b,
  input  logic                  m_rdy,
  input  logic [RES_W-1:0]      m_res
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_ptr, w_ptr_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0]   r_done, w_done_nxt;
  logic [N_REQ-1:0]   r_err, w_err_nxt;
  logic [RES_W-1:0]   r_res, w_res_nxt;
  logic               r_m_ld, w_m_ld_nxt;
  logic [OP_W-1:0]    r_m_a, w_m_a_nxt;
  logic [OP_W-1:0]    r_m_b, w_m_b_nxt;
  logic [N_REQ-1:0]   w_pick;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_res_nxt   = r_res;
    w_m_ld_nxt  = 1'b0;
    w_m_a_nxt   = r_m_a;
    w_m_b_nxt   = r_m_b;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_LOAD;
          w_gnt_nxt   = w_pick;
          w_m_ld_nxt  = 1'b1;
          for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
              w_m_a_nxt = op_a[i*OP_W +: OP_W];
              w_m_b_nxt = op_b[i*OP_W +: OP_W];
            end
          end
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (m_rdy) begin
          w_state_nxt = ST_DONE;
          w_res_nxt   = m_res;
          w_done_nxt  = r_gnt;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = r_gnt;
          w_gnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_ptr_nxt   = onehot_to_idx(r_gnt) + 2'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_res   <= '0;
      r_m_ld  <= 1'b0;
      r_m_a   <= '0;
      r_m_b   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_res   <= w_res_nxt;
      r_m_ld  <= w_m_ld_nxt;
      r_m_a   <= w_m_a_nxt;
      r_m_b   <= w_m_b_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign err  = r_err;
  assign res  = r_res;
  assign busy = (r_state != ST_IDLE);
  assign m_ld = r_m_ld;
  assign m_a  = r_m_a;
  assign m_b  = r_m_b;

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters; the value is fixed at 4 for this release.
REQ-002 The block SHALL have parameter TIMEOUT, default 32, giving the maximum number of WAIT cycles before a multiply is aborted.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req  in  4  per-requester level request; held high until the matching done or err pulse.
REQ-006 op_a  in  32  operand A per requester; requester i uses bits [8i+7:8i].
REQ-007 op_b  in  32  operand B per requester; same packing as op_a.
REQ-008 gnt  out  4  one-hot grant, or zero when no operation is in flight.
REQ-009 done  out  4  one-cycle completion pulse for the served requester.
REQ-010 err  out  4  one-cycle timeout pulse for the served requester.
REQ-011 res  out  16  latched product; valid in the done cycle and held until the next done.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 m_ld  out  1  one-cycle load strobe to the shared 8x8 multiplier.
REQ-014 m_a, m_b  out  8 each  multiplier operands, registered.
REQ-015 m_rdy  in  1  multiplier result-valid.
REQ-016 m_res  in  16  multiplier product.

Function
REQ-017 The FSM SHALL have exactly four states, IDLE, LOAD, WAIT and DONE; an expired timeout returns from WAIT to IDLE.
REQ-018 IDLE: when req is nonzero, the FSM SHALL pick a winner round-robin, register gnt, m_a and m_b from the winner's slice, and enter LOAD on the next edge.
REQ-019 LOAD: m_ld SHALL be 1 for exactly this one cycle, then the FSM SHALL enter WAIT.
REQ-020 WAIT: the timeout counter SHALL be cleared on entry and SHALL count each WAIT cycle.
REQ-021 WAIT: when m_rdy=1, the block SHALL latch m_res into res and enter DONE.
REQ-022 WAIT: when the count reaches TIMEOUT with m_rdy=0, the block SHALL pulse err[winner], clear gnt and return to IDLE.
REQ-023 When m_rdy=1 and the count reaches TIMEOUT in the same cycle, m_rdy SHALL take precedence (completion, no err).
REQ-024 An m_rdy asserted in IDLE or LOAD SHALL be ignored as stale.
REQ-025 DONE: done[winner] SHALL be 1 for one cycle, gnt SHALL clear, the FSM SHALL return to IDLE, and the pointer SHALL become (winner+1) mod 4.
REQ-026 Round-robin: priority SHALL start at the pointer and wrap 3 to 0; the pointer SHALL reset to 0 and SHALL NOT advance on err.
REQ-027 Latency: with req first high at edge 0 in IDLE, LOAD SHALL be at cycle 1, WAIT from cycle 2; m_rdy sampled at edge n SHALL give done at cycle n+1.
REQ-028 Minimum occupancy SHALL be 4 cycles (m_rdy one cycle after LOAD), so back-to-back grants are at least 4 cycles apart.
REQ-029 A req change after grant SHALL NOT abort the operation; done still pulses, and operands are never re-sampled mid-operation.
REQ-030 New requests arriving while busy SHALL wait and SHALL be considered only in IDLE.
REQ-031 m_a and m_b SHALL be held stable from LOAD until the FSM leaves WAIT.

Reset
REQ-032 Asserting reset SHALL force IDLE, with gnt, done, err, m_ld and busy at 0, res, m_a and m_b at 0, and the pointer and counter at 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation with no done or err, and a late m_rdy after release SHALL be ignored.

Structure
REQ-034 Package rgbw_pkg SHALL hold the state enum, N_REQ, OP_W=8 and RES_W=16.
REQ-035 The round-robin pick (req and pointer in, one-hot out) SHALL be the combinational sub-module rr_pick4.
REQ-036 The implementation SHALL be a single always block for sequential logic plus rr_pick4.

Verification
REQ-037 Single request: req=0001, op_a[7:0]=0x0F, op_b[7:0]=0x11, multiplier latency 3 -> m_ld at cycle 1, done=0001 at cycle 5, res=0x00FF.
REQ-038 All four request at once from reset -> service order 0,1,2,3, each done exactly once, operands never mixed.
REQ-039 Requester 2 just served (pointer=3), then req=1010 -> requester 3 granted before requester 1.
REQ-040 m_rdy never asserted, TIMEOUT=32 -> err[winner] pulses 32 WAIT cycles after entry, no done, pointer unchanged, next grant proceeds.
REQ-041 Reset pulsed during WAIT, then m_rdy=1 after release -> outputs all 0, no done, FSM stays IDLE.
REQ-042 m_rdy and the TIMEOUT count in the same cycle -> done pulses, err stays 0.
